// File: rtl/awg_sample_unpacker.sv
// -----------------------------------------------------------------------------
// awg_sample_unpacker
//
// Unpacks wide words of packed DAC samples into a registered stream of one
// sample per enable cycle. Lane 0 (least significant bits) is emitted first.
// When the block runs dry after having produced samples, it flags a sticky
// underrun. In that case it outputs either zero or the last sample, as
// selected by underrun_mode.
//
// Ports
//   aclk           in   1         rising-edge clock
//   areset         in   1         synchronous active-high reset
//   s_word_tdata   in   WORD_W    packed word, lane k = [k*SAMPLE_W +: SAMPLE_W]
//   s_word_tvalid  in   1         word valid
//   s_word_tready  out  1         word accepted when high with s_word_tvalid
//   enable         in   1         sample strobe, one sample per cycle while high
//   underrun_mode  in   1         0: output zero on underrun, 1: hold last sample
//   underrun_clr   in   1         clears the sticky underrun flag
//   wave_out       out  SAMPLE_W  registered sample
//   wave_valid     out  1         one-cycle pulse per newly emitted sample
//   underrun       out  1         sticky underrun flag
//   sample_cnt     out  32        emitted sample count, wraps
// -----------------------------------------------------------------------------
module awg_sample_unpacker #(
    parameter int SAMPLE_W         = 16,
    parameter int SAMPLES_PER_WORD = 2
) (
    input  logic                                 aclk,
    input  logic                                 areset,
    input  logic [SAMPLE_W*SAMPLES_PER_WORD-1:0] s_word_tdata,
    input  logic                                 s_word_tvalid,
    output logic                                 s_word_tready,
    input  logic                                 enable,
    input  logic                                 underrun_mode,
    input  logic                                 underrun_clr,
    output logic [SAMPLE_W-1:0]                  wave_out,
    output logic                                 wave_valid,
    output logic                                 underrun,
    output logic [31:0]                          sample_cnt
);

    localparam int WORD_W = SAMPLE_W * SAMPLES_PER_WORD;
    // One spare index bit is kept for the single-lane case; it stays at zero.
    localparam int IDX_W  = (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES_PER_WORD - 1);

    typedef enum logic [0:0] {
        ST_EMPTY  = 1'b0,
        ST_LOADED = 1'b1
    } state_t;

    state_t              state_r;
    logic [WORD_W-1:0]   word_r;
    logic [IDX_W-1:0]    idx_r;
    logic                primed_r;
    logic [SAMPLE_W-1:0] wave_out_r;
    logic                wave_valid_r;
    logic                underrun_r;
    logic [31:0]         sample_cnt_r;

    logic                last_lane_s;
    logic                tready_s;
    logic                accept_s;
    logic [SAMPLE_W-1:0] lane_s;

    assign last_lane_s = (idx_r == LAST_IDX);
    // Ready is held low during reset so no word is taken while state is cleared.
    assign tready_s    = ~areset & ((state_r == ST_EMPTY) | (enable & last_lane_s));
    assign accept_s    = s_word_tvalid & tready_s;
    assign lane_s      = word_r[int'(idx_r) * SAMPLE_W +: SAMPLE_W];

    // Word holding, lane sequencing, output sample and underrun tracking.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r      <= ST_EMPTY;
            word_r       <= {WORD_W{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            primed_r     <= 1'b0;
            wave_out_r   <= {SAMPLE_W{1'b0}};
            wave_valid_r <= 1'b0;
            underrun_r   <= 1'b0;
            sample_cnt_r <= 32'd0;
        end else begin
            wave_valid_r <= 1'b0;
            case (state_r)
                ST_EMPTY: begin
                    // Running dry after start-up is an underrun; before the
                    // first sample it is just idle and the output stays zero.
                    if (enable && primed_r) begin
                        underrun_r <= 1'b1;
                        if (!underrun_mode) begin
                            wave_out_r <= {SAMPLE_W{1'b0}};
                        end else begin
                            wave_out_r <= wave_out_r;
                        end
                    end else if (underrun_clr) begin
                        underrun_r <= 1'b0;
                    end else begin
                        underrun_r <= underrun_r;
                    end
                    // A word taken here is only emitted from the next cycle on.
                    if (accept_s) begin
                        word_r  <= s_word_tdata;
                        idx_r   <= {IDX_W{1'b0}};
                        state_r <= ST_LOADED;
                    end else begin
                        state_r <= ST_EMPTY;
                    end
                end
                ST_LOADED: begin
                    if (underrun_clr) begin
                        underrun_r <= 1'b0;
                    end else begin
                        underrun_r <= underrun_r;
                    end
                    if (enable) begin
                        wave_out_r   <= lane_s;
                        wave_valid_r <= 1'b1;
                        sample_cnt_r <= sample_cnt_r + 32'd1;
                        primed_r     <= 1'b1;
                        if (last_lane_s) begin
                            // Accepting on the last lane gives a gapless hand-over.
                            idx_r <= {IDX_W{1'b0}};
                            if (accept_s) begin
                                word_r  <= s_word_tdata;
                                state_r <= ST_LOADED;
                            end else begin
                                state_r <= ST_EMPTY;
                            end
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end else begin
                        state_r <= ST_LOADED;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                    idx_r   <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    assign s_word_tready = tready_s;
    assign wave_out      = wave_out_r;
    assign wave_valid    = wave_valid_r;
    assign underrun      = underrun_r;
    assign sample_cnt    = sample_cnt_r;

endmodule
